// File: rtl/wb2axi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wb2axi_pkg
// Purpose : Shared AXI encodings and the bridge FSM state type for wb2axi.
// Contents: RESP_* response codes, BURST_INCR, SIZE_4B, LEN_SINGLE, state_t.
// Revision: 1.0 - initial release
// ============================================================================
package wb2axi_pkg;

  // AXI response encodings; bit 1 set means the access failed.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Every transaction is one 32-bit INCR beat.
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [7:0] LEN_SINGLE = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ADDR = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_RESP = 3'd4,
    S_DONE    = 3'd5
  } state_t;

endpackage : wb2axi_pkg
`default_nettype wire

// File: rtl/wb2axi.sv
`default_nettype none
// ============================================================================
// Module  : wb2axi
// Purpose : Classic Wishbone (32-bit) to AXI4 (64-bit) initiator bridge.
//           One single-beat AXI transaction is outstanding at any time.
// Ports   : i_clk, i_rst (async, active high)
//           i_wb_*       Wishbone slave side (word address, data, sel, we,
//                        cyc, stb); o_wb_rdt/o_wb_ack/o_wb_err responses
//           o_aw*/o_w*/i_b*   AXI write address, data and response channels
//           o_ar*/i_r*        AXI read address and data channels
// Revision: 1.0 - initial release
// ============================================================================
module wb2axi
  import wb2axi_pkg::*;
#(
  parameter int                  AW       = 32,
  parameter int                  ID_WIDTH = 1,
  parameter logic [ID_WIDTH-1:0] AXI_ID   = '0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  // Wishbone
  input  logic [AW-3:0]       i_wb_adr,
  input  logic [31:0]         i_wb_dat,
  input  logic [3:0]          i_wb_sel,
  input  logic                i_wb_we,
  input  logic                i_wb_cyc,
  input  logic                i_wb_stb,
  output logic [31:0]         o_wb_rdt,
  output logic                o_wb_ack,
  output logic                o_wb_err,
  // AXI write address
  output logic [ID_WIDTH-1:0] o_awid,
  output logic [AW-1:0]       o_awaddr,
  output logic [7:0]          o_awlen,
  output logic [2:0]          o_awsize,
  output logic [1:0]          o_awburst,
  output logic                o_awvalid,
  input  logic                i_awready,
  // AXI write data
  output logic [63:0]         o_wdata,
  output logic [7:0]          o_wstrb,
  output logic                o_wlast,
  output logic                o_wvalid,
  input  logic                i_wready,
  // AXI write response
  input  logic [ID_WIDTH-1:0] i_bid,
  input  logic [1:0]          i_bresp,
  input  logic                i_bvalid,
  output logic                o_bready,
  // AXI read address
  output logic [ID_WIDTH-1:0] o_arid,
  output logic [AW-1:0]       o_araddr,
  output logic [7:0]          o_arlen,
  output logic [2:0]          o_arsize,
  output logic [1:0]          o_arburst,
  output logic                o_arvalid,
  input  logic                i_arready,
  // AXI read data
  input  logic [ID_WIDTH-1:0] i_rid,
  input  logic [63:0]         i_rdata,
  input  logic [1:0]          i_rresp,
  input  logic                i_rlast,
  input  logic                i_rvalid,
  output logic                o_rready
);

  state_t        r_state;
  state_t        w_state_nxt;

  logic [AW-3:0] r_adr;
  logic [31:0]   r_dat;
  logic [3:0]    r_sel;
  logic          r_aw_done;
  logic          r_w_done;
  logic          r_err;
  logic [31:0]   r_rdt;

  logic          w_req;
  logic          w_awvalid;
  logic          w_wvalid;
  logic          w_bready;
  logic          w_arvalid;
  logic          w_rready;
  logic          w_in_done;

  // Only one transaction is ever in flight, so IDs, rlast and the low
  // response bit (EXOKAY vs OKAY) carry no information for the bridge.
  logic          w_unused;
  assign w_unused = ^{i_bid, i_rid, i_rlast, i_bresp[0], i_rresp[0]};

  assign w_req = i_wb_cyc & i_wb_stb;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and channel handshake outputs. Valid/ready outputs decode
  // straight from registered state so an asynchronous reset clears them at
  // once.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_awvalid   = 1'b0;
    w_wvalid    = 1'b0;
    w_bready    = 1'b0;
    w_arvalid   = 1'b0;
    w_rready    = 1'b0;
    w_in_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_nxt = i_wb_we ? S_WR_ADDR : S_RD_ADDR;
        end
      end
      S_WR_ADDR: begin
        // AW and W complete independently; a channel that has finished
        // stops driving valid and no longer depends on its ready.
        w_awvalid = ~r_aw_done;
        w_wvalid  = ~r_w_done;
        if ((r_aw_done | i_awready) && (r_w_done | i_wready)) begin
          w_state_nxt = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        w_bready = 1'b1;
        if (i_bvalid) begin
          w_state_nxt = S_DONE;
        end
      end
      S_RD_ADDR: begin
        w_arvalid = 1'b1;
        if (i_arready) begin
          w_state_nxt = S_RD_RESP;
        end
      end
      S_RD_RESP: begin
        w_rready = 1'b1;
        if (i_rvalid) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // Requests are deliberately not sampled here; stb is still high
        // from the finished access during this cycle.
        w_in_done   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request capture, per-channel completion flags and response capture
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_adr     <= '0;
      r_dat     <= '0;
      r_sel     <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_err     <= 1'b0;
      r_rdt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_adr     <= i_wb_adr;
            r_dat     <= i_wb_dat;
            r_sel     <= i_wb_sel;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end
        end
        S_WR_ADDR: begin
          if (i_awready) begin
            r_aw_done <= 1'b1;
          end
          if (i_wready) begin
            r_w_done <= 1'b1;
          end
        end
        S_WR_RESP: begin
          if (i_bvalid) begin
            r_err <= i_bresp[1];
          end
        end
        S_RD_RESP: begin
          if (i_rvalid) begin
            r_err <= i_rresp[1];
            r_rdt <= r_adr[0] ? i_rdata[63:32] : i_rdata[31:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_awid    = AXI_ID;
  assign o_awaddr  = {r_adr, 2'b00};
  assign o_awlen   = LEN_SINGLE;
  assign o_awsize  = SIZE_4B;
  assign o_awburst = BURST_INCR;
  assign o_awvalid = w_awvalid;

  // The 32-bit word is replicated on both halves; the strobe picks the lane
  // selected by byte-address bit 2.
  assign o_wdata   = {r_dat, r_dat};
  assign o_wstrb   = r_adr[0] ? {r_sel, 4'h0} : {4'h0, r_sel};
  assign o_wlast   = 1'b1;
  assign o_wvalid  = w_wvalid;

  assign o_bready  = w_bready;

  assign o_arid    = AXI_ID;
  assign o_araddr  = {r_adr, 2'b00};
  assign o_arlen   = LEN_SINGLE;
  assign o_arsize  = SIZE_4B;
  assign o_arburst = BURST_INCR;
  assign o_arvalid = w_arvalid;

  assign o_rready  = w_rready;

  // A master that abandoned its cycle never sees the completion.
  assign o_wb_rdt  = r_rdt;
  assign o_wb_ack  = w_in_done & ~r_err & i_wb_cyc;
  assign o_wb_err  = w_in_done &  r_err & i_wb_cyc;

endmodule : wb2axi
`default_nettype wire

// File: tb/tb_wb2axi.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb2axi
// Purpose : Self-checking bench for wb2axi. A Wishbone master task issues
//           accesses; an AXI slave process with its own 64-bit memory answers
//           them; a 32-bit word reference memory predicts read data.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wb2axi;

  localparam int AW = 32;

  logic           clk = 1'b0;
  logic           rst;
  always #5 clk = ~clk;

  logic [AW-3:0]  wb_adr;
  logic [31:0]    wb_dat;
  logic [3:0]     wb_sel;
  logic           wb_we, wb_cyc, wb_stb;
  logic [31:0]    wb_rdt;
  logic           wb_ack, wb_err;
  logic [0:0]     awid, arid, bid, rid;
  logic [AW-1:0]  awaddr, araddr;
  logic [7:0]     awlen, arlen;
  logic [2:0]     awsize, arsize;
  logic [1:0]     awburst, arburst;
  logic           awvalid, awready, arvalid, arready;
  logic [63:0]    wdata, rdata;
  logic [7:0]     wstrb;
  logic           wlast, wvalid, wready;
  logic [1:0]     bresp, rresp;
  logic           bvalid, bready, rlast, rvalid, rready;

  wb2axi #(.AW(AW), .ID_WIDTH(1), .AXI_ID(1'b0)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_sel(wb_sel), .i_wb_we(wb_we),
    .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb),
    .o_wb_rdt(wb_rdt), .o_wb_ack(wb_ack), .o_wb_err(wb_err),
    .o_awid(awid), .o_awaddr(awaddr), .o_awlen(awlen), .o_awsize(awsize),
    .o_awburst(awburst), .o_awvalid(awvalid), .i_awready(awready),
    .o_wdata(wdata), .o_wstrb(wstrb), .o_wlast(wlast), .o_wvalid(wvalid),
    .i_wready(wready),
    .i_bid(bid), .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(bready),
    .o_arid(arid), .o_araddr(araddr), .o_arlen(arlen), .o_arsize(arsize),
    .o_arburst(arburst), .o_arvalid(arvalid), .i_arready(arready),
    .i_rid(rid), .i_rdata(rdata), .i_rresp(rresp), .i_rlast(rlast),
    .i_rvalid(rvalid), .o_rready(rready)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: Wishbone-visible 32-bit words, word addresses 0..31.
  logic [31:0] ref_mem [0:31];
  logic [31:0] last_rdt;

  // AXI slave memory: 64-bit words indexed by byte address bits [6:3].
  logic [63:0] s_mem [0:15];

  // Expectations for the access in flight.
  logic [AW-1:0] exp_addr;
  logic [63:0]   exp_wdata;
  logic [7:0]    exp_strb;
  logic [1:0]    cur_resp;

  // Slave behaviour controls.
  bit fast    = 1'b1;
  bit hold_b  = 1'b0;
  int aw_hold = 0;

  // Slave bookkeeping.
  int tick = 0;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, aw_cyc, w_cyc;
  bit hs_aw, hs_w, hs_b, hs_ar, hs_r;
  bit pv_aw, pv_w, pv_ar;
  bit have_aw, have_w, b_pend, r_pend;
  int b_wait, r_wait;
  logic [AW-1:0] c_awaddr, c_araddr;
  logic [63:0]   c_wdata;
  logic [7:0]    c_wstrb;

  task automatic slave_clear();
    hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
    pv_aw = 0; pv_w = 0; pv_ar = 0;
    have_aw = 0; have_w = 0; b_pend = 0; r_pend = 0;
    bvalid = 1'b0; rvalid = 1'b0;
  endtask

  // AXI slave: at each falling edge, commit the handshakes that happened on
  // the preceding rising edge, then drive the next cycle's ready/valid and
  // note which handshakes the coming rising edge will complete.
  initial begin
    awready = 0; wready = 0; arready = 0;
    bvalid = 0; bresp = 0; bid = 0;
    rvalid = 0; rresp = 0; rid = 0; rdata = 0; rlast = 0;
    slave_clear();
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    b_wait = 0; r_wait = 0;
    forever begin
      @(negedge clk);
      tick++;
      if (!rst && pv_aw && !hs_aw) check("awvalid_hold", awvalid, 1);
      if (!rst && pv_w  && !hs_w)  check("wvalid_hold",  wvalid,  1);
      if (!rst && pv_ar && !hs_ar) check("arvalid_hold", arvalid, 1);
      if (hs_aw) begin aw_cnt++; aw_cyc = tick; have_aw = 1; check("awvalid_drop", awvalid, 0); end
      if (hs_w)  begin w_cnt++;  w_cyc  = tick; have_w  = 1; check("wvalid_drop",  wvalid,  0); end
      if (hs_b)  begin b_cnt++; bvalid = 1'b0; end
      if (hs_ar) begin
        ar_cnt++; check("arvalid_drop", arvalid, 0);
        r_pend = 1; r_wait = fast ? 0 : $urandom_range(0, 3);
      end
      if (hs_r)  begin r_cnt++; rvalid = 1'b0; end
      if (have_aw && have_w) begin
        have_aw = 0; have_w = 0;
        if (!cur_resp[1]) begin
          for (int b = 0; b < 8; b++)
            if (c_wstrb[b]) s_mem[c_awaddr[6:3]][8*b +: 8] = c_wdata[8*b +: 8];
        end
        b_pend = 1; b_wait = fast ? 0 : $urandom_range(0, 3);
      end
      if (b_pend && !hold_b) begin
        if (b_wait == 0) begin bvalid = 1'b1; bresp = cur_resp; b_pend = 0; end
        else b_wait--;
      end
      if (r_pend) begin
        if (r_wait == 0) begin
          rvalid = 1'b1; rdata = s_mem[c_araddr[6:3]]; rresp = cur_resp; rlast = 1'b1;
          r_pend = 0;
        end else r_wait--;
      end
      if (fast) begin
        awready = 1; wready = 1; arready = 1;
      end else begin
        awready = ($urandom_range(0, 2) == 0);
        wready  = ($urandom_range(0, 2) == 0);
        arready = ($urandom_range(0, 2) == 0);
      end
      if (aw_hold > 0 && awvalid) begin awready = 0; aw_hold--; end
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      hs_b  = bvalid && bready;
      hs_ar = arvalid && arready;
      hs_r  = rvalid && rready;
      if (hs_aw) begin
        c_awaddr = awaddr;
        check("awaddr", awaddr, exp_addr);
        check("aw_const", {awid, awlen, awsize, awburst}, {1'b0, 8'd0, 3'd2, 2'd1});
      end
      if (hs_w) begin
        c_wdata = wdata; c_wstrb = wstrb;
        check("wdata", wdata, exp_wdata);
        check("wstrb", wstrb, exp_strb);
        check("wlast", wlast, 1);
      end
      if (hs_ar) begin
        c_araddr = araddr;
        check("araddr", araddr, exp_addr);
        check("ar_const", {arid, arlen, arsize, arburst}, {1'b0, 8'd0, 3'd2, 2'd1});
      end
      pv_aw = awvalid; pv_w = wvalid; pv_ar = arvalid;
    end
  end

  // Set up expectations and drive one Wishbone request.
  task automatic start_req(input bit we, input logic [4:0] wa, input logic [31:0] dat,
                           input logic [3:0] sel, input int resp);
    int pick;
    exp_addr  = AW'(wa) << 2;
    exp_wdata = {dat, dat};
    exp_strb  = 8'(sel) << (4 * wa[0]);
    if (resp < 0) begin
      pick = $urandom_range(0, 7);
      cur_resp = (pick < 4) ? 2'b00 : (pick < 6) ? 2'b01 : (pick == 6) ? 2'b10 : 2'b11;
    end else begin
      cur_resp = 2'(resp);
    end
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    wb_adr = (AW-2)'(wa); wb_dat = dat; wb_sel = sel; wb_we = we;
    wb_cyc = 1'b1; wb_stb = 1'b1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
    return r;
  endfunction

  // One complete Wishbone access; lat counts clock cycles from the first
  // cycle stb is seen through the cycle ack/err is seen.
  task automatic wb_xfer(input bit we, input logic [4:0] wa, input logic [31:0] dat,
                         input logic [3:0] sel, input bit hold, input int resp,
                         output int lat);
    bit exp_e;
    start_req(we, wa, dat, sel, resp);
    exp_e = cur_resp[1];
    lat = 1;
    do begin
      @(negedge clk); #1;
      lat++;
    end while (!wb_ack && !wb_err && lat < 200);
    check("no_timeout", (lat < 200), 1);
    check("ack", wb_ack, !exp_e);
    check("err", wb_err, exp_e);
    if (we) begin
      check("beats_w", {aw_cnt[7:0], w_cnt[7:0], b_cnt[7:0], ar_cnt[7:0]}, 32'h01010100);
      check("rdt_hold", wb_rdt, last_rdt);
      if (!exp_e) ref_mem[wa] = merge(ref_mem[wa], dat, sel);
    end else begin
      check("beats_r", {ar_cnt[7:0], r_cnt[7:0], aw_cnt[7:0], w_cnt[7:0]}, 32'h01010000);
      check("rdata", wb_rdt, ref_mem[wa]);
      last_rdt = ref_mem[wa];
    end
    if (!hold) begin
      wb_cyc = 0; wb_stb = 0; wb_we = 0;
      @(negedge clk); #1;
      check("single_pulse", {wb_ack, wb_err}, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, lat2, k;
    bit we, hold;
    rst = 1'b1;
    wb_adr = '0; wb_dat = '0; wb_sel = '0; wb_we = 0; wb_cyc = 0; wb_stb = 0;
    last_rdt = '0;
    for (int i = 0; i < 16; i++) s_mem[i] = {$urandom, $urandom};
    s_mem[8] = 64'h11223344_55667788;
    for (int i = 0; i < 16; i++) begin
      ref_mem[2*i]   = s_mem[i][31:0];
      ref_mem[2*i+1] = s_mem[i][63:32];
    end

    // Reset state
    @(negedge clk); #1;
    check("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    check("rst_wb", {wb_ack, wb_err, wb_rdt}, 0);
    @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;

    // Reads of both lanes of one 64-bit word
    wb_xfer(0, 5'h11, 0, 0, 0, 0, lat);
    check("rd44_data", wb_rdt, 32'h11223344);
    check("rd_latency", lat, 4);
    wb_xfer(0, 5'h10, 0, 0, 0, 0, lat);
    check("rd40_data", wb_rdt, 32'h55667788);

    // Minimum-latency write
    wb_xfer(1, 5'h10, 32'hDEADBEEF, 4'hF, 0, 0, lat);
    check("wr_latency", lat, 4);

    // Upper-lane write, W accepted three cycles before AW
    aw_hold = 3;
    wb_xfer(1, 5'h11, 32'hCAFEF00D, 4'h3, 0, 0, lat);
    check("w_before_aw", aw_cyc - w_cyc, 3);

    // Error responses, and EXOKAY as success
    wb_xfer(0, 5'h05, 0, 0, 0, 2, lat);
    wb_xfer(1, 5'h06, 32'h0BADF00D, 4'hF, 0, 3, lat);
    wb_xfer(1, 5'h07, 32'h600DF00D, 4'hF, 0, 1, lat);
    wb_xfer(0, 5'h06, 0, 0, 0, 0, lat);
    wb_xfer(0, 5'h07, 0, 0, 0, 0, lat);

    // Back-to-back reads with stb held high
    wb_xfer(0, 5'h10, 0, 0, 1, 0, lat);
    wb_xfer(0, 5'h11, 0, 0, 0, 0, lat2);
    check("b2b_first", lat, 4);
    check("b2b_second", lat2, 5);

    // Asynchronous reset while waiting for the write response
    hold_b = 1'b1;
    start_req(1, 5'h12, 32'h13572468, 4'hF, 0);
    k = 0;
    do begin @(negedge clk); #1; k++; end while (!bready && k < 50);
    check("reach_wr_resp", bready, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valids", {awvalid, wvalid, bready, arvalid, rready, wb_ack, wb_err}, 0);
    check("async_rst_rdt", wb_rdt, 0);
    last_rdt = '0;
    wb_cyc = 0; wb_stb = 0; wb_we = 0;
    slave_clear();
    hold_b = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    wb_xfer(1, 5'h12, 32'h24681357, 4'hF, 0, 0, lat);
    wb_xfer(0, 5'h12, 0, 0, 0, 0, lat);

    // Master abandons the cycle: AXI side completes, no ack is seen
    start_req(1, 5'h03, 32'hA5A5_5A5A, 4'hF, 0);
    @(negedge clk); #1;
    wb_cyc = 0; wb_stb = 0; wb_we = 0;
    k = 0;
    do begin
      @(negedge clk); #1; k++;
      check("abandon_no_ack", {wb_ack, wb_err}, 0);
    end while (b_cnt == 0 && k < 50);
    repeat (3) begin
      @(negedge clk); #1;
      check("abandon_no_ack", {wb_ack, wb_err}, 0);
    end
    check("abandon_beats", {aw_cnt[7:0], w_cnt[7:0], b_cnt[7:0]}, 24'h010101);
    ref_mem[3] = 32'hA5A5_5A5A;
    wb_xfer(0, 5'h03, 0, 0, 0, 0, lat);

    // Randomized traffic against a stalling slave
    fast = 1'b0;
    for (int n = 0; n < 80; n++) begin
      we   = $urandom_range(0, 1);
      hold = ($urandom_range(0, 3) == 0) && (n != 79);
      wb_xfer(we, 5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
              hold, -1, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_wb2axi
`default_nettype wire
